instr_mem_loader: RTL

Programs the instruction memory at run time by writing 32-bit instruction words into it. Bytes arrive one at a time from an upstream source, such as a UART receiver or debug port, over a valid/ready handshake. The block assembles them into words and issues one single-cycle write per word at consecutive word-aligned byte addresses. It is the write side of the instruction memory port, which the fetch path reads with a byte address A, word index A/4, and 32-bit data RD.

---
 rtl/instr_mem_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// Assembles big-endian bytes into 32-bit words and writes them to the instruction memory.
// Latency: byte_ready rises 1 cycle after start; we rises 1 cycle after the 4th byte; 5 cycles/word sustained.
// Backpressure: byte_ready drops during the write cycle and outside a load; the block waits indefinitely for bytes.
module instr_mem_loader #(
  parameter int unsigned MEM_DEPTH = 100,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] num_words,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] num_q, num_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wcnt_q, wcnt_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] part_q, part_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [31:0] wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        byte_acc;
  logic [31:0] wcnt_inc;

  assign byte_acc = byte_valid && ready_q;
  assign wcnt_inc = wcnt_q + 32'd1;

  // Next-state and registered-output computation; everything holds unless a state changes it.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    part_d  = part_q;
    ready_d = ready_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_words > 32'(MEM_DEPTH)) begin
            // Oversized request: flag it and never touch memory.
            error_d = 1'b1;
          end else if (num_words == 32'd0) begin
            error_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            error_d = 1'b0;
            num_d   = num_words;
            addr_d  = BASE_ADDR;
            wcnt_d  = 32'd0;
            bcnt_d  = 2'd0;
            part_d  = 24'd0;
            busy_d  = 1'b1;
            ready_d = 1'b1;
            state_d = S_COLLECT;
          end
        end
      end

      S_COLLECT: begin
        if (byte_acc) begin
          if (bcnt_q == 2'd3) begin
            // Fourth byte completes the word; earlier bytes sit in the upper lanes.
            we_d    = 1'b1;
            wd_d    = {part_q, byte_in};
            wa_d    = addr_q;
            ready_d = 1'b0;
            bcnt_d  = 2'd0;
            part_d  = 24'd0;
            state_d = S_WRITE;
          end else begin
            part_d = {part_q[15:0], byte_in};
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end

      S_WRITE: begin
        addr_d = addr_q + 32'd4;
        wcnt_d = wcnt_inc;
        if (wcnt_inc == num_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          ready_d = 1'b1;
          state_d = S_COLLECT;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any load in progress and drops the partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      num_q   <= 32'd0;
      addr_q  <= 32'd0;
      wcnt_q  <= 32'd0;
      bcnt_q  <= 2'd0;
      part_q  <= 24'd0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= 32'd0;
      wd_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      part_q  <= part_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign byte_ready = ready_q;
  assign we         = we_q;
  assign wa         = wa_q;
  assign wd         = wd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
